// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seg7_pkg
// Brief   : Shared constants and types for the seven-segment readback checker.
//           Segment constants are active-high abcdefg (bit 0 = segment a).
// Revision: 1.0 - initial release
// ============================================================================
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_A     = 7'h77;
   localparam logic [6:0] SEG_B     = 7'h7C;
   localparam logic [6:0] SEG_C     = 7'h39;
   localparam logic [6:0] SEG_D     = 7'h5E;
   localparam logic [6:0] SEG_E     = 7'h79;
   localparam logic [6:0] SEG_F     = 7'h71;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   // Settle tracker states: idle, counting stable samples, pattern already published
   typedef enum logic [1:0] {
      WAIT   = 2'd0,
      SETTLE = 2'd1,
      HELD   = 2'd2
   } seg7_state_t;

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_digit_decode.sv
`default_nettype none
// ============================================================================
// Module  : seg7_digit_decode
// Brief   : Combinational decode of one 7-bit segment pattern into a hex
//           digit plus a legal flag. Inverts the pattern first when the
//           display is active-low. Blank and unlisted patterns are illegal.
// Revision: 1.0 - initial release
// ============================================================================
module seg7_digit_decode
   import seg7_pkg::*;
(
   input  logic [6:0] i_seg,
   input  logic       i_active_low,
   output logic [3:0] o_digit,
   output logic       o_legal
);

   logic [6:0] w_pat;

   assign w_pat = i_active_low ? ~i_seg : i_seg;

   // Pattern lookup; anything outside the sixteen glyphs is flagged illegal
   always_comb begin
      o_digit = 4'h0;
      o_legal = 1'b1;
      case (w_pat)
         SEG_0:   o_digit = 4'h0;
         SEG_1:   o_digit = 4'h1;
         SEG_2:   o_digit = 4'h2;
         SEG_3:   o_digit = 4'h3;
         SEG_4:   o_digit = 4'h4;
         SEG_5:   o_digit = 4'h5;
         SEG_6:   o_digit = 4'h6;
         SEG_7:   o_digit = 4'h7;
         SEG_8:   o_digit = 4'h8;
         SEG_9:   o_digit = 4'h9;
         SEG_A:   o_digit = 4'hA;
         SEG_B:   o_digit = 4'hB;
         SEG_C:   o_digit = 4'hC;
         SEG_D:   o_digit = 4'hD;
         SEG_E:   o_digit = 4'hE;
         SEG_F:   o_digit = 4'hF;
         default: o_legal = 1'b0;
      endcase
   end

endmodule : seg7_digit_decode
`default_nettype wire

// File: rtl/seg7_readback_checker.sv
`default_nettype none
// ============================================================================
// Module  : seg7_readback_checker
// Brief   : Samples a 4-digit seven-segment drive bus, waits until it has been
//           stable for STABLE_CYCLES samples, then publishes the decoded hex
//           value or flags an illegal pattern.
//           Optional macro SEG7_RB_INCR_CHECK_EN adds a check that each legal
//           publish (after the first) equals the previous value + 1.
// Revision: 1.0 - initial release
// ============================================================================
module seg7_readback_checker
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES  = 4,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter int CNT_W          = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [27:0]      HEX_arr,
   output logic [15:0]      value,
   output logic             value_vld,
   output logic             illegal,
   output logic             err_sticky,
   output logic [CNT_W-1:0] upd_cnt,
   output logic             step_err
);

   localparam int            c_CW         = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(STABLE_CYCLES - 1);
   // A blank display: no segment lit in either polarity
   localparam logic [27:0]   c_BLANK_BUS  = SEG_ACTIVE_LOW ? {28{1'b1}} : 28'h0;

   logic [27:0]      r_hex_q;
   logic [27:0]      r_hex_prev;
   logic             w_diff;

   seg7_state_t      r_state;
   seg7_state_t      w_state_nxt;
   logic [c_CW-1:0]  r_cnt;
   logic [c_CW-1:0]  w_cnt_nxt;
   logic             w_publish;

   logic [15:0]      w_decoded;
   logic [3:0]       w_legal;
   logic             w_all_legal;

   logic [15:0]      r_value;
   logic             r_vld;
   logic             r_ill;
   logic             r_sticky;
   logic [CNT_W-1:0] r_upd_cnt;
   logic             w_step_hit;

   // Two-deep sample pipeline; a change is seen as a mismatch between stages
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hex_q    <= c_BLANK_BUS;
         r_hex_prev <= c_BLANK_BUS;
      end else begin
         r_hex_q    <= HEX_arr;
         r_hex_prev <= r_hex_q;
      end
   end

   assign w_diff = (r_hex_q != r_hex_prev);

   for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      seg7_digit_decode u_dec (
         .i_seg        (r_hex_q[7*gi +: 7]),
         .i_active_low (SEG_ACTIVE_LOW),
         .o_digit      (w_decoded[4*gi +: 4]),
         .o_legal      (w_legal[gi])
      );
   end

   assign w_all_legal = &w_legal;

   // Settle tracker state and stability counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= WAIT;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next state: any change restarts settling; a full stable run lands in HELD
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         WAIT, HELD: begin
            if (w_diff) begin
               w_state_nxt = SETTLE;
               w_cnt_nxt   = '0;
            end
         end
         SETTLE: begin
            if (w_diff) begin
               w_cnt_nxt = '0;
            end else if (r_cnt == c_CNT_LAST) begin
               w_state_nxt = HELD;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Publish strobe: last stable sample reached with no fresh change
   always_comb begin
      w_publish = (r_state == SETTLE) && !w_diff && (r_cnt == c_CNT_LAST);
   end

`ifdef SEG7_RB_INCR_CHECK_EN
   logic r_ref_vld;
   logic r_step;
   logic w_step_bad;

   // The published value doubles as the reference; r_ref_vld marks it as meaningful
   assign w_step_bad = r_ref_vld && (w_decoded != (r_value + 16'd1));
   assign w_step_hit = w_publish && w_all_legal && w_step_bad;

   // Increment-check reference tracking and step error pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ref_vld <= 1'b0;
         r_step    <= 1'b0;
      end else begin
         r_step <= w_step_hit;
         if (w_publish && w_all_legal) begin
            r_ref_vld <= 1'b1;
         end
      end
   end

   assign step_err = r_step;
`else
   assign w_step_hit = 1'b0;
   assign step_err   = 1'b0;
`endif

   // Published value, pulses, sticky error and update counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_value   <= 16'h0;
         r_vld     <= 1'b0;
         r_ill     <= 1'b0;
         r_sticky  <= 1'b0;
         r_upd_cnt <= '0;
      end else begin
         r_vld <= 1'b0;
         r_ill <= 1'b0;
         if (w_publish) begin
            if (w_all_legal) begin
               r_value   <= w_decoded;
               r_vld     <= 1'b1;
               r_upd_cnt <= r_upd_cnt + CNT_W'(1);
            end else begin
               r_ill <= 1'b1;
            end
         end
         if ((w_publish && !w_all_legal) || w_step_hit) begin
            r_sticky <= 1'b1;
         end
      end
   end

   assign value      = r_value;
   assign value_vld  = r_vld;
   assign illegal    = r_ill;
   assign err_sticky = r_sticky;
   assign upd_cnt    = r_upd_cnt;

endmodule : seg7_readback_checker
`default_nettype wire
